// File: rtl/gemm_operand_stager.sv
// Stages one 4x4 GEMM operand set (input, weight, psum rows) from the gemmFIFO and streams it to the array.
// Optional macro GEMM_ORDER_CHECK_EN adds a sticky order_err flag for type-0 or duplicate rows.
module gemm_operand_stager #(
    parameter int BITS_PER_ROW = 64,
    parameter int ROWS         = 4,
    parameter int MAT_T_W      = 2
) (
    input  logic                                         CLK,
    input  logic                                         nRST,
    input  logic                                         gemmFIFO_empty,
    input  logic [MAT_T_W+2+$clog2(ROWS)+BITS_PER_ROW-1:0] gemmFIFO_rdata,
    output logic                                         gemmFIFO_REN,
    input  logic                                         array_ready,
    output logic                                         w_valid,
    output logic [$clog2(ROWS)-1:0]                      w_row,
    output logic [BITS_PER_ROW-1:0]                      w_data,
    output logic                                         x_valid,
    output logic [$clog2(ROWS)-1:0]                      x_row,
    output logic [BITS_PER_ROW-1:0]                      x_data,
    output logic [BITS_PER_ROW-1:0]                      ps_data,
    output logic [1:0]                                   res_mat_s,
    output logic                                         gemm_issued,
    output logic                                         busy
`ifdef GEMM_ORDER_CHECK_EN
    ,
    output logic                                         order_err
`endif
);

    // state   | meaning
    // COLLECT | popping rows into the local buffers until all 12 are valid
    // WLOAD   | streaming weight rows 0..3
    // STREAM  | streaming input rows 0..3 alongside psum rows 0..3
    // DONE    | one-cycle issue pulse, valid bits cleared
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WLOAD   = 2'd1,
        STREAM  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int ROW_W = $clog2(ROWS);
    localparam int DW    = BITS_PER_ROW;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      x_buf_q  [ROWS];
    logic [DW-1:0]      x_buf_d  [ROWS];
    logic [DW-1:0]      w_buf_q  [ROWS];
    logic [DW-1:0]      w_buf_d  [ROWS];
    logic [DW-1:0]      ps_buf_q [ROWS];
    logic [DW-1:0]      ps_buf_d [ROWS];
    logic [ROWS-1:0]    x_vld_q, x_vld_d;
    logic [ROWS-1:0]    w_vld_q, w_vld_d;
    logic [ROWS-1:0]    ps_vld_q, ps_vld_d;
    logic [1:0]         res_mat_s_q, res_mat_s_d;
    logic               run_q, run_d;

    logic [DW-1:0]      pop_data;
    logic [ROW_W-1:0]   pop_row;
    logic [1:0]         pop_ms;
    logic [MAT_T_W-1:0] pop_t;
    logic               all_valid;
    logic               pop;

    assign pop_data  = gemmFIFO_rdata[DW-1:0];
    assign pop_row   = gemmFIFO_rdata[DW +: ROW_W];
    assign pop_ms    = gemmFIFO_rdata[DW+ROW_W +: 2];
    assign pop_t     = gemmFIFO_rdata[DW+ROW_W+2 +: MAT_T_W];
    assign all_valid = &{x_vld_q, w_vld_q, ps_vld_q};

    // run_q keeps REN low while reset is held and for the first edge after release
    assign pop = run_q && (state_q == COLLECT) && !gemmFIFO_empty && !all_valid;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_buf_d     = x_buf_q;
        w_buf_d     = w_buf_q;
        ps_buf_d    = ps_buf_q;
        x_vld_d     = x_vld_q;
        w_vld_d     = w_vld_q;
        ps_vld_d    = ps_vld_q;
        res_mat_s_d = res_mat_s_q;
        run_d       = 1'b1;

        case (state_q)
            COLLECT: begin
                if (pop) begin
                    if (pop_t == MAT_T_W'(1)) begin
                        x_buf_d[pop_row] = pop_data;
                        x_vld_d[pop_row] = 1'b1;
                    end else if (pop_t == MAT_T_W'(2)) begin
                        w_buf_d[pop_row] = pop_data;
                        w_vld_d[pop_row] = 1'b1;
                    end else if (pop_t == MAT_T_W'(3)) begin
                        ps_buf_d[pop_row] = pop_data;
                        ps_vld_d[pop_row] = 1'b1;
                        res_mat_s_d       = pop_ms;
                    end
                end
                // Completing pop moves straight to WLOAD so the first weight beat follows it by one cycle
                if (&{x_vld_d, w_vld_d, ps_vld_d}) begin
                    state_d = WLOAD;
                    cnt_d   = '0;
                end
            end
            WLOAD: begin
                if (array_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == ROW_W'(ROWS-1)) begin
                        state_d = STREAM;
                        cnt_d   = '0;
                    end
                end
            end
            STREAM: begin
                if (array_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == ROW_W'(ROWS-1)) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end
                end
            end
            DONE: begin
                x_vld_d  = '0;
                w_vld_d  = '0;
                ps_vld_d = '0;
                cnt_d    = '0;
                state_d  = COLLECT;
            end
            default: begin
                state_d = COLLECT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            x_buf_q     <= '{default: '0};
            w_buf_q     <= '{default: '0};
            ps_buf_q    <= '{default: '0};
            x_vld_q     <= '0;
            w_vld_q     <= '0;
            ps_vld_q    <= '0;
            res_mat_s_q <= '0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_buf_q     <= x_buf_d;
            w_buf_q     <= w_buf_d;
            ps_buf_q    <= ps_buf_d;
            x_vld_q     <= x_vld_d;
            w_vld_q     <= w_vld_d;
            ps_vld_q    <= ps_vld_d;
            res_mat_s_q <= res_mat_s_d;
            run_q       <= run_d;
        end
    end

`ifdef GEMM_ORDER_CHECK_EN
    logic order_err_q, order_err_d;
    logic dup_row;

    always_comb begin
        dup_row = 1'b0;
        if (pop_t == MAT_T_W'(1)) begin
            dup_row = x_vld_q[pop_row];
        end else if (pop_t == MAT_T_W'(2)) begin
            dup_row = w_vld_q[pop_row];
        end else if (pop_t == MAT_T_W'(3)) begin
            dup_row = ps_vld_q[pop_row];
        end
        order_err_d = order_err_q;
        if (pop && ((pop_t == '0) || dup_row)) begin
            order_err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            order_err_q <= 1'b0;
        end else begin
            order_err_q <= order_err_d;
        end
    end

    assign order_err = order_err_q;
`endif

    // Valids and data are decoded from registered state only; array_ready never reaches them combinationally
    always_comb begin
        gemmFIFO_REN = pop;
        w_valid      = (state_q == WLOAD);
        x_valid      = (state_q == STREAM);
        w_row        = w_valid ? cnt_q : '0;
        x_row        = x_valid ? cnt_q : '0;
        w_data       = w_valid ? w_buf_q[cnt_q] : '0;
        x_data       = x_valid ? x_buf_q[cnt_q] : '0;
        ps_data      = x_valid ? ps_buf_q[cnt_q] : '0;
        res_mat_s    = res_mat_s_q;
        gemm_issued  = (state_q == DONE);
        busy         = (state_q != COLLECT);
    end

endmodule
